match_timer_ctrl: RTL
=====================

# match_timer_ctrl

Sequencing controller for the time-mode match countdown. It loads the configured match length, generates a 1 s tick from the system clock, and counts down to zero. It supports start/restart, pause/resume and abort, and signals match end. It sits between the button/debounce logic and the seven-segment time display. It feeds the display a registered BCD value and drives the game-over and warning flags consumed by the pong game logic.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1, countdown rate; DIV = CLK_HZ/TICK_HZ, integer, ≥ 2.
- WARN_SEC, 5, warning threshold in seconds.

Ports:
- clk  in  1  system clock; everything on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- max_time  in  8  match length in seconds (0..255); sampled only on load.
- start  in  1  single-cycle pulse; start or restart the match.
- pause  in  1  single-cycle pulse; toggles pause/resume.
- abort  in  1  single-cycle pulse; return to IDLE.
- remaining  out  8  seconds left.
- bcd  out  12  {hundreds, tens, ones} of remaining, 4 bits each.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- expired  out  1  high in DONE.
- warn  out  1  high in RUN/PAUSE when 0 < remaining ≤ WARN_SEC.
- game_over  out  1  single-cycle pulse on entry to DONE.

## Operation
- The FSM has four states: IDLE, RUN, PAUSE and DONE. Encoding is 2 bits.
- Reset values: state IDLE, remaining 0, bcd 0, prescaler 0, and all flags 0.
- IDLE:
  - remaining loads max_time every cycle, so the display previews the setting.
  - start with max_time ≠ 0 → RUN. remaining = max_time and the prescaler is cleared.
  - start with max_time = 0 → DONE, with the game_over pulse.
- RUN:
  - The prescaler counts 0..DIV-1. At DIV-1 a tick occurs and the prescaler wraps to 0.
  - On a tick, remaining decrements.
  - A tick with remaining = 1 gives remaining = 0 and → DONE.
- PAUSE: the prescaler and remaining hold their values. pause → RUN, and the prescaler resumes from the held value.
- DONE: remaining holds 0 and expired = 1. start reloads exactly as from IDLE.
- start in RUN or PAUSE restarts the match: remaining = max_time, prescaler = 0, → RUN.
- abort in any state → IDLE and prescaler = 0. game_over does not pulse.
- Priority for simultaneous inputs is abort > start > pause > tick.
- A tick coincident with pause in RUN applies the decrement, then enters PAUSE.
- A tick coincident with start or abort is discarded.
- pause in IDLE or DONE is ignored.
- remaining never underflows. No decrement occurs at 0.

## Timing
- State, remaining and the flags update on the clock edge that follows the input pulse or tick.
- running, paused and expired are decoded from registered state. They change in the same cycle as the state.
- game_over is high for exactly one cycle. That cycle is the first cycle in DONE, in which remaining already reads 0.
- bcd is registered from remaining: one-cycle latency after any remaining change.
- warn is registered alongside remaining (same cycle). It is low in IDLE and DONE.
- Tick period in RUN is exactly DIV cycles. The first tick after start comes DIV cycles after the start edge.
- Total RUN time from start to DONE is max_time × DIV cycles, plus the cycles spent in PAUSE.
- reset_n asserted mid-match clears everything immediately (asynchronously). Release is synchronous to the next edge.

## Structure
- Shared package `pong_pkg` holds:
  - the timer state typedef (IDLE/RUN/PAUSE/DONE);
  - TIME_W = 8;
  - the BCD digit width of 4.
- Sub-module `bin2bcd8` is combinational: 8-bit binary to three BCD digits by double-dabble. Its output is registered in match_timer_ctrl.
- The prescaler width is $clog2(DIV).

## Test plan
Bench parameters: CLK_HZ = 100, TICK_HZ = 10, so DIV = 10.
- **Reset and IDLE preview:** reset, set max_time = 20 → remaining = 20 and bcd = 0x020 within 2 cycles; running = expired = 0.
- **Full countdown:** start with max_time = 3 → remaining 3 → 2 → 1 → 0 at 10-cycle intervals. game_over pulses once, exactly 30 cycles after start. expired stays high afterwards.
- **Pause/resume:**
  - Pause 4 cycles after start, hold 50 cycles, resume.
  - The first decrement occurs 6 cycles after resume.
  - paused = 1 during the hold and remaining is unchanged.
- **Simultaneous events:**
  - pause on a tick cycle → decrement applied, then PAUSE.
  - start on a tick cycle → remaining = max_time with no decrement.
  - abort together with start → IDLE.
- **Boundaries:**
  - max_time = 0 with start → DONE in the next cycle with game_over.
  - max_time = 255 → bcd = 0x255.
  - warn rises when remaining reaches 5 and falls when remaining reaches 0.
- **Reset mid-run:** assert reset_n low while remaining = 7 → all outputs 0 immediately; after release the block is in IDLE previewing max_time.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared timer state type and display widths for the pong time-mode logic
package pong_pkg;
    localparam int TIME_W = 8;
    localparam int BCD_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;
endpackage

// File: rtl/bin2bcd8.sv
// bin2bcd8: combinational 8-bit binary to three BCD digits by double-dabble
module bin2bcd8
    import pong_pkg::*;
(
    input  logic [TIME_W-1:0]    bin,
    output logic [3*BCD_W-1:0]   bcd
);
    logic [TIME_W+3*BCD_W-1:0] s;
    always_comb begin
        s = (TIME_W+3*BCD_W)'(bin);
        for (int i = 0; i < TIME_W; i++) begin
            for (int d = 0; d < 3; d++)
                s[TIME_W+BCD_W*d +: BCD_W] = s[TIME_W+BCD_W*d +: BCD_W] > 4'd4 ? s[TIME_W+BCD_W*d +: BCD_W] + 4'd3 : s[TIME_W+BCD_W*d +: BCD_W];
            s = s << 1;
        end
    end
    assign bcd = s[TIME_W +: 3*BCD_W];
endmodule

// File: rtl/match_timer_ctrl.sv
// match_timer_ctrl: match countdown FSM with tick prescaler, registered BCD display value and end-of-match flags
module match_timer_ctrl
    import pong_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1,
    parameter int WARN_SEC = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [TIME_W-1:0]    max_time,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 abort,
    output logic [TIME_W-1:0]    remaining,
    output logic [3*BCD_W-1:0]   bcd,
    output logic                 running,
    output logic                 paused,
    output logic                 expired,
    output logic                 warn,
    output logic                 game_over
);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = $clog2(DIV);
    timer_state_t state, state_n;
    logic [PS_W-1:0] ps, ps_n;
    logic [TIME_W-1:0] rem_n;
    logic [3*BCD_W-1:0] bcd_c;
    logic tick, last, go_n, warn_n;
    assign tick = state == RUN && ps == PS_W'(DIV - 1);
    assign last = tick && remaining == TIME_W'(1);
    // abort > start > pause > tick; a final tick wins over a coincident pause
    always_comb begin
        state_n = state;
        ps_n = ps;
        rem_n = remaining;
        go_n = 1'b0;
        if (abort) begin
            state_n = IDLE;
            ps_n = '0;
            rem_n = max_time;
        end else if (start) begin
            state_n = max_time == '0 ? DONE : RUN;
            ps_n = '0;
            rem_n = max_time;
            go_n = max_time == '0;
        end else if (state == IDLE) begin
            rem_n = max_time;
        end else if (state == PAUSE) begin
            state_n = pause ? RUN : PAUSE;
        end else if (state == RUN) begin
            ps_n = tick ? '0 : ps + 1'b1;
            rem_n = tick && remaining != '0 ? remaining - 1'b1 : remaining;
            state_n = last ? DONE : pause ? PAUSE : RUN;
            go_n = last;
        end
        warn_n = (state_n == RUN || state_n == PAUSE) && rem_n != '0 && rem_n <= TIME_W'(WARN_SEC);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ps <= '0;
            remaining <= '0;
            bcd <= '0;
            warn <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state <= state_n;
            ps <= ps_n;
            remaining <= rem_n;
            bcd <= bcd_c;
            warn <= warn_n;
            game_over <= go_n;
        end
    end
    assign running = state == RUN;
    assign paused  = state == PAUSE;
    assign expired = state == DONE;
    bin2bcd8 u_bcd (.bin(remaining), .bcd(bcd_c));
endmodule
